pkt_rd_sched: RTL and testbench
===============================

PKT_RD_SCHED -- requirements
Module: pkt_rd_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, buffer read address width.
REQ-002 SHALL have parameter DATA_W, default 32, buffer word and stream width.
REQ-003 SHALL have parameter HDR_TAG, default 8'hA5, tag byte in the header word.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port i_msync_n  in  1  main sync, active-low, synchronous to clk.
REQ-007 SHALL have port i_pkt_len  in  ADDR_W+1  data words per frame, 0..1024, sampled at frame start.
REQ-008 SHALL have port o_rd_addr  out  ADDR_W  ping-pong buffer read address.
REQ-009 SHALL have port i_rd_data  in  DATA_W  buffer read data, valid 1 clk after o_rd_addr.
REQ-010 SHALL have port o_tx_data  out  DATA_W  stream word to the UDP packet builder.
REQ-011 SHALL have port o_tx_valid  out  1  stream word valid.
REQ-012 SHALL have port i_tx_ready  in  1  downstream ready.
REQ-013 SHALL have port o_tx_sop  out  1  first word of packet (header).
REQ-014 SHALL have port o_tx_eop  out  1  last word of packet.
REQ-015 SHALL have port o_busy  out  1  frame transfer in progress.
REQ-016 SHALL have port o_frame_cnt  out  16  frames started since reset.
REQ-017 SHALL have port o_overrun_cnt  out  8  syncs arriving while busy, saturating at 255.

Function
REQ-018 SHALL detect a sync as i_msync_n high in the previous clk and low now (one-cycle msync pulse).
REQ-019 SHALL use the FSM states IDLE, HDR, DATA and FLUSH.
REQ-020 SHALL, in IDLE, on msync or a pending sync: latch i_pkt_len, increment o_frame_cnt (wraps at 16 bits), and go to HDR.
REQ-021 SHALL, in HDR, push one header word {HDR_TAG, 8'(min(len,255)), frame_cnt[15:0]}, with o_tx_sop=1, into the output buffer.
REQ-022 SHALL make the header word also carry o_tx_eop=1 when the latched length is 0; the FSM then returns to IDLE.
REQ-023 SHALL, in DATA, issue addresses 0..len-1 in order, one per clk, and only while the output buffer can accept the returning word (1-clk RAM latency accounted for).
REQ-024 SHALL tag the word returned for address len-1 with o_tx_eop=1.
REQ-025 SHALL go from DATA to FLUSH after the last address, and from FLUSH to IDLE when the output buffer is empty.
REQ-026 SHALL hold o_busy=1 in every state except IDLE.
REQ-027 SHALL hold o_tx_data, o_tx_sop and o_tx_eop stable while o_tx_valid=1 and i_tx_ready=0; a word transfers when valid and ready are both 1.
REQ-028 SHALL never drop or duplicate a word under any i_tx_ready pattern.
REQ-029 SHALL never stall the stream when i_tx_ready is held 1: one word per clk after the header.
REQ-030 SHALL, on msync while busy: set a pending flag, increment o_overrun_cnt, and complete the current packet unchanged.
REQ-031 SHALL start the pending frame from IDLE the next clk; multiple syncs while busy set only one pending flag.
REQ-032 SHALL drive o_rd_addr to 0 when not in DATA.

Reset
REQ-033 SHALL, on rst assertion, immediately clear: FSM to IDLE, o_tx_valid=0, o_tx_sop=0, o_tx_eop=0, o_busy=0, o_rd_addr=0, o_frame_cnt=0, o_overrun_cnt=0, the pending flag and the buffer contents.
REQ-034 SHALL initialise the previous-msync register to 1.
REQ-035 SHALL abandon a frame that is mid-transfer when rst is asserted, with no eop emitted.

Structure
REQ-036 SHALL place the FSM state encoding, the header layout field positions and the counter widths in the shared package pkt_pkg.
REQ-037 SHALL contain one sub-module, pkt_skid_buf: a 2-entry valid/ready buffer of width DATA_W+2 (data, sop, eop).

Verification
REQ-038 SHALL check: len=4, ready=1, sync -> header A5_04_0001 with sop, then words at addr 0..3 on consecutive clks, eop on the 4th; busy falls after the flush.
REQ-039 SHALL check: len=0, sync -> a single word A5_00_0001 with sop=1 and eop=1; the RAM is never addressed.
REQ-040 SHALL check: len=16, ready toggling randomly -> exactly 17 words in order, no gaps in the data sequence.
REQ-041 SHALL check: a second sync during a len=32 frame -> overrun_cnt=1, the first packet is complete, and the second header with frame_cnt=2 starts immediately after it.
REQ-042 SHALL check: rst asserted mid-DATA -> all outputs clear in the same clk; the next sync yields a header with frame_cnt=1.
REQ-043 SHALL check: len=1024 -> the header length field is 0xFF and exactly 1024 data words follow.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared definitions for the packet read scheduler: FSM encoding, header
// field layout and status counter widths.
package pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_FLUSH = 2'd3
    } pkt_state_e;

    localparam int HDR_W       = 32;
    localparam int HDR_TAG_LSB = 24;
    localparam int HDR_TAG_W   = 8;
    localparam int HDR_LEN_LSB = 16;
    localparam int HDR_LEN_W   = 8;
    localparam int HDR_CNT_LSB = 0;
    localparam int HDR_CNT_W   = 16;

    localparam int FRAME_CNT_W   = 16;
    localparam int OVERRUN_CNT_W = 8;

    function automatic logic [HDR_W-1:0] make_hdr(
        input logic [HDR_TAG_W-1:0] tag,
        input logic [HDR_LEN_W-1:0] len8,
        input logic [HDR_CNT_W-1:0] cnt
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_TAG_LSB +: HDR_TAG_W] = tag;
        h[HDR_LEN_LSB +: HDR_LEN_W] = len8;
        h[HDR_CNT_LSB +: HDR_CNT_W] = cnt;
        return h;
    endfunction

endpackage

// File: rtl/pkt_skid_buf.sv
// Two-entry output buffer between the read scheduler and the stream port.
// Entry 0 always holds the oldest word, so the output is a plain register.
module pkt_skid_buf #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_word,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   count
);

    // Handshake: a word moves on either side exactly when valid and ready are
    // both 1 at a rising edge; a producer holding valid keeps its word stable,
    // and ready never depends on valid from the same side.
    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_word  = mem0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= in_word;
                    else               mem1 <= in_word;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                // push blocked when full, so a simultaneous push/pop means count==1
                2'b11: mem0 <= in_word;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pkt_rd_sched.sv
// Per-frame read scheduler: on main sync emits a tagged header word, then
// streams len words from the ping-pong buffer through a 2-entry output buffer.
module pkt_rd_sched
    import pkt_pkg::*;
#(
    parameter int         ADDR_W  = 10,
    parameter int         DATA_W  = 32,
    parameter logic [7:0] HDR_TAG = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_msync_n,
    input  logic [ADDR_W:0]          i_pkt_len,
    output logic [ADDR_W-1:0]        o_rd_addr,
    input  logic [DATA_W-1:0]        i_rd_data,
    output logic [DATA_W-1:0]        o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_tx_sop,
    output logic                     o_tx_eop,
    output logic                     o_busy,
    output logic [FRAME_CNT_W-1:0]   o_frame_cnt,
    output logic [OVERRUN_CNT_W-1:0] o_overrun_cnt,
    output logic [1:0]               o_dbg_state
);

    pkt_state_e        state;
    logic              msync_q;
    logic              sync;
    logic              pending;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   addr_cnt;
    logic              last_addr;
    logic              rd_vld;
    logic              rd_last;
    logic              issue;
    logic              hdr_push;
    logic [7:0]        len8;
    logic [DATA_W-1:0] hdr_word;
    logic [2:0]        occ_next;

    logic              buf_push;
    logic              buf_pop;
    logic              buf_in_ready;
    logic [1:0]        buf_count;
    logic [DATA_W+1:0] buf_in_word;
    logic [DATA_W+1:0] buf_out_word;

    assign sync        = msync_q & ~i_msync_n;
    assign last_addr   = (addr_cnt == len_q - 1'b1);
    assign o_rd_addr   = (state == ST_DATA) ? addr_cnt[ADDR_W-1:0] : '0;
    assign o_dbg_state = state;
    assign o_tx_data   = buf_out_word[DATA_W+1:2];
    assign o_tx_sop    = buf_out_word[1];
    assign o_tx_eop    = buf_out_word[0];

    always_comb begin
        len8        = (len_q > (ADDR_W+1)'(255)) ? 8'hFF : len_q[7:0];
        hdr_word    = DATA_W'(make_hdr(HDR_TAG, len8, o_frame_cnt));
        hdr_push    = (state == ST_HDR) && buf_in_ready;
        buf_push    = hdr_push || rd_vld;
        buf_pop     = o_tx_valid && i_tx_ready;
        buf_in_word = hdr_push ? {hdr_word, 1'b1, (len_q == '0)}
                               : {i_rd_data, 1'b0, rd_last};
        // Occupancy after this edge; a read issued now lands one clk later and
        // must find a free slot even if the consumer stalls then.
        occ_next    = {1'b0, buf_count} + {2'b0, buf_push} - {2'b0, buf_pop};
        issue       = 1'b0;
        if (state == ST_HDR)
            issue = hdr_push && (len_q != '0) && (occ_next <= 3'd1);
        else if (state == ST_DATA)
            issue = (occ_next <= 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            msync_q       <= 1'b1;
            pending       <= 1'b0;
            len_q         <= '0;
            addr_cnt      <= '0;
            rd_vld        <= 1'b0;
            rd_last       <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_cnt   <= '0;
            o_overrun_cnt <= '0;
        end else begin
            msync_q <= i_msync_n;
            rd_vld  <= issue;
            rd_last <= issue && last_addr;
            if (issue) addr_cnt <= addr_cnt + 1'b1;

            if (sync && state != ST_IDLE) begin
                pending <= 1'b1;
                if (o_overrun_cnt != 8'hFF) o_overrun_cnt <= o_overrun_cnt + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (sync || pending) begin
                        len_q       <= i_pkt_len;
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        pending     <= 1'b0;
                        addr_cnt    <= '0;
                        o_busy      <= 1'b1;
                        state       <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    // Address 0 is already on the bus here, so the first read
                    // rides along with the header and the stream has no gap.
                    if (hdr_push) begin
                        if (len_q == '0) begin
                            o_busy <= 1'b0;
                            state  <= ST_IDLE;
                        end else if (issue && last_addr) begin
                            state <= ST_FLUSH;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (issue && last_addr) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (buf_count == 2'd0 && !rd_vld) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pkt_skid_buf #(
        .W(DATA_W + 2)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_word   (buf_in_word),
        .in_valid  (buf_push),
        .in_ready  (buf_in_ready),
        .out_word  (buf_out_word),
        .out_valid (o_tx_valid),
        .out_ready (i_tx_ready),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_pkt_rd_sched.sv
// Bench for pkt_rd_sched: a RAM model, a packet-level scoreboard built from
// the frame rules, and directed plus randomized frames and ready patterns.
module tb_pkt_rd_sched;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_msync_n = 1'b1;
    logic [ADDR_W:0]   i_pkt_len = '0;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data = '0;
    logic [DATA_W-1:0] o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready = 1'b1;
    logic              o_tx_sop;
    logic              o_tx_eop;
    logic              o_busy;
    logic [15:0]       o_frame_cnt;
    logic [7:0]        o_overrun_cnt;
    logic [1:0]        o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int n_words  = 0;
    int model_fno = 0;
    bit ready_mode = 1'b0;
    bit gap_chk = 1'b0;
    bit addr_nz = 1'b0;
    bit hold_pend = 1'b0;
    logic [DATA_W+1:0] held_word;
    logic [DATA_W+1:0] exp_q[$];

    pkt_rd_sched #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .HDR_TAG(8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_msync_n    (i_msync_n),
        .i_pkt_len    (i_pkt_len),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_tx_sop     (o_tx_sop),
        .o_tx_eop     (o_tx_eop),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt),
        .o_overrun_cnt(o_overrun_cnt),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [DATA_W-1:0] ram_fn(input logic [ADDR_W-1:0] a);
        return 32'h5A00_0000 ^ {6'h0, a, 6'h0, a};
    endfunction

    always @(posedge clk) i_rd_data <= ram_fn(o_rd_addr);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected packet for one frame: header, then RAM words 0..len-1.
    task automatic push_pkt(input int len);
        logic [7:0]  l8;
        logic [15:0] fno;
        model_fno++;
        l8  = (len > 255) ? 8'hFF : 8'(len);
        fno = 16'(model_fno);
        exp_q.push_back({8'hA5, l8, fno, 1'b1, (len == 0)});
        for (int i = 0; i < len; i++)
            exp_q.push_back({ram_fn(ADDR_W'(i)), 1'b0, (i == len - 1)});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [DATA_W+1:0] word;
        logic [DATA_W+1:0] exp;
        word = {o_tx_data, o_tx_sop, o_tx_eop};
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(o_tx_valid), 64'd1);
                check("hold_word", 64'(word), 64'(held_word));
            end
            hold_pend = o_tx_valid && !i_tx_ready;
            held_word = word;
            if (o_rd_addr != '0) addr_nz = 1'b1;
            if (o_tx_valid && i_tx_ready) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp = exp_q.pop_front();
                    check("word", 64'(word), 64'(exp));
                end
                if (gap_chk && !o_tx_sop) check("gap", 64'(cyc - last_cyc), 64'd1);
                last_cyc = cyc;
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_tx_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_fno = 0;
        hold_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_sync();
        @(posedge clk);
        #1 i_msync_n = 1'b0;
        @(posedge clk);
        #1 i_msync_n = 1'b1;
    endtask

    task automatic start_frame(input int len);
        i_pkt_len = (ADDR_W+1)'(len);
        push_pkt(len);
        send_sync();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((o_busy || o_tx_valid || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", 64'(n < budget), 64'd1);
        if (n >= budget) exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w0;
        int bound;

        // Reset values, during and after reset
        #2;
        check("rst_valid", 64'(o_tx_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        do_reset();
        check("rst_rd_addr", 64'(o_rd_addr), 64'd0);
        check("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
        check("rst_overrun", 64'(o_overrun_cnt), 64'd0);
        check("rst_sop_eop", 64'({o_tx_sop, o_tx_eop}), 64'd0);

        // len=4, ready high: header then gapless data
        ready_mode = 1'b0;
        gap_chk = 1'b1;
        w0 = n_words;
        start_frame(4);
        check("busy_on_start", 64'(o_busy), 64'd1);
        wait_done(100);
        gap_chk = 1'b0;
        check("len4_words", 64'(n_words - w0), 64'd5);
        check("len4_busy_end", 64'(o_busy), 64'd0);
        check("len4_frame_cnt", 64'(o_frame_cnt), 64'd1);

        // len=0: header only with sop+eop, no reads
        do_reset();
        addr_nz = 1'b0;
        w0 = n_words;
        start_frame(0);
        wait_done(50);
        check("len0_words", 64'(n_words - w0), 64'd1);
        check("len0_addr", 64'(addr_nz), 64'd0);

        // len=16, random ready
        do_reset();
        ready_mode = 1'b1;
        w0 = n_words;
        start_frame(16);
        wait_done(400);
        check("len16_words", 64'(n_words - w0), 64'd17);

        // Sync during a len=32 frame
        do_reset();
        ready_mode = 1'b0;
        start_frame(32);
        repeat (10) @(posedge clk);
        i_pkt_len = 11'd7;
        push_pkt(7);
        send_sync();
        check("ovr_cnt_now", 64'(o_overrun_cnt), 64'd1);
        wait_done(300);
        check("ovr_cnt_end", 64'(o_overrun_cnt), 64'd1);
        check("ovr_frame_cnt", 64'(o_frame_cnt), 64'd2);

        // Several syncs while busy collapse into one pending frame
        ready_mode = 1'b1;
        start_frame(20);
        i_pkt_len = 11'd3;
        push_pkt(3);
        repeat (3) send_sync();
        check("multi_ovr_cnt", 64'(o_overrun_cnt), 64'd4);
        wait_done(500);
        check("multi_frame_cnt", 64'(o_frame_cnt), 64'd4);

        // Reset in the middle of DATA
        do_reset();
        ready_mode = 1'b0;
        start_frame(64);
        bound = 0;
        while (o_rd_addr < 10'd8 && bound < 100) begin
            @(posedge clk);
            #1;
            bound++;
        end
        check("mid_reach_data", 64'(bound < 100), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_valid", 64'(o_tx_valid), 64'd0);
        check("mid_sop_eop", 64'({o_tx_sop, o_tx_eop}), 64'd0);
        check("mid_busy", 64'(o_busy), 64'd0);
        check("mid_rd_addr", 64'(o_rd_addr), 64'd0);
        check("mid_frame_cnt", 64'(o_frame_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_fno = 0;
        start_frame(3);
        wait_done(100);
        check("post_rst_frame_cnt", 64'(o_frame_cnt), 64'd1);

        // Largest frame: length field saturates, all words follow gapless
        do_reset();
        ready_mode = 1'b0;
        gap_chk = 1'b1;
        w0 = n_words;
        start_frame(1024);
        wait_done(1300);
        gap_chk = 1'b0;
        check("len1024_words", 64'(n_words - w0), 64'd1025);

        // Randomized frames and ready, including length boundaries
        do_reset();
        ready_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int len;
            case (k)
                0: len = 1;
                1: len = 255;
                2: len = 256;
                default: len = int'($urandom_range(0, 40));
            endcase
            repeat ($urandom_range(0, 5)) @(posedge clk);
            start_frame(len);
            wait_done(1500);
        end
        check("rand_frame_cnt", 64'(o_frame_cnt), 64'(model_fno));
        check("rand_overrun", 64'(o_overrun_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
